dequant_block: RTL and testbench

DEQUANT_BLOCK -- requirements
Module: dequant_block

---
 rtl/dequant_pkg.sv | 43 ++++
 rtl/zigzag_lut.sv | 23 ++
 rtl/dequant_block.sv | 163 ++++++++++++++++
 tb/tb_dequant_block.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dequant_pkg.sv
// Shared types and tables for the 8x8 coefficient dequantizer.
// Zigzag scan order and per-diagonal shift amounts for Q0/Q1.
package dequant_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ZERO,
    S_VALUE,
    S_FILL,
    S_DONE
  } state_e;

  localparam logic [6:0] LAST_POS = 7'd63;

  // Zigzag scan position -> raster index (row*8+col).
  localparam logic [5:0] ZZ_RASTER [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Shift indexed by diagonal d=row+col (0..14); entry 15 unused.
  localparam logic [2:0] Q0_SHIFT [16] = '{
    3'd3, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
    3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6
  };

  localparam logic [2:0] Q1_SHIFT [16] = '{
    3'd3, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
    3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5
  };

  function automatic logic [3:0] diag(input logic [5:0] r);
    return {1'b0, r[5:3]} + {1'b0, r[2:0]};
  endfunction

endpackage

// File: rtl/zigzag_lut.sv
// Zigzag position to raster address and dequant shift.
// Purely combinational lookup.
module zigzag_lut
  import dequant_pkg::*;
(
  input  logic [5:0] pos_i,
  input  logic       q_i,
  output logic [6:0] addr_o,
  output logic [2:0] shift_o
);

  logic [5:0] rast;
  logic [3:0] d;

  // Map scan position to raster slot, pick shift by diagonal.
  always_comb begin
    rast    = ZZ_RASTER[pos_i];
    d       = diag(rast);
    addr_o  = {1'b0, rast};
    shift_o = q_i ? Q1_SHIFT[d] : Q0_SHIFT[d];
  end

endmodule

// File: rtl/dequant_block.sv
// Run/value symbol decoder writing one dequantized 8x8 block.
// Emits 64 zigzag-ordered writes, then a finish pulse.
module dequant_block
  import dequant_pkg::*;
(
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        start,
  input  logic        q_select,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [5:0]  sym_run,
  input  logic [8:0]  sym_value,
  input  logic        sym_eob,
  output logic [6:0]  DP_RAM_address_a,
  output logic [31:0] DP_write_DATA_a,
  output logic        DP_write_enable_a,
  output logic        busy,
  output logic        finish,
  output logic        run_error
);

  state_e      state_q, state_d;
  logic [6:0]  pos_q, pos_d;
  logic [5:0]  run_q, run_d;
  logic [8:0]  val_q, val_d;
  logic        qsel_q, qsel_d;
  logic        err_q, err_d;

  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        fin_q, fin_d;

  logic [6:0]  end_pos;
  logic        overflow;
  logic [6:0]  lut_addr;
  logic [2:0]  lut_shift;
  logic [15:0] prod;

  // Outputs are registered against the next state, so the
  // lookup is driven by the next position and matrix.
  zigzag_lut u_lut (
    .pos_i   (pos_d[5:0]),
    .q_i     (qsel_d),
    .addr_o  (lut_addr),
    .shift_o (lut_shift)
  );

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    run_d    = run_q;
    val_d    = val_q;
    qsel_d   = qsel_q;
    err_d    = err_q;
    end_pos  = pos_q + {1'b0, sym_run};
    overflow = end_pos > LAST_POS;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCEPT;
          pos_d   = '0;
          run_d   = '0;
          qsel_d  = q_select;
          err_d   = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (sym_valid) begin
          if (sym_eob) begin
            state_d = S_FILL;
          end else if (overflow) begin
            err_d   = 1'b1;
            state_d = S_FILL;
          end else begin
            val_d = sym_value;
            if (sym_run != 6'd0) begin
              run_d   = sym_run;
              state_d = S_ZERO;
            end else begin
              state_d = S_VALUE;
            end
          end
        end
      end
      S_ZERO: begin
        pos_d = pos_q + 7'd1;
        run_d = run_q - 6'd1;
        if (run_q == 6'd1) state_d = S_VALUE;
      end
      S_VALUE: begin
        pos_d   = pos_q + 7'd1;
        state_d = (pos_q == LAST_POS) ? S_DONE : S_ACCEPT;
      end
      S_FILL: begin
        pos_d = pos_q + 7'd1;
        if (pos_q == LAST_POS) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered output values for the coming state.
  always_comb begin
    we_d    = state_d inside {S_ZERO, S_VALUE, S_FILL};
    ready_d = state_d == S_ACCEPT;
    busy_d  = state_d inside {S_ACCEPT, S_ZERO, S_VALUE, S_FILL};
    fin_d   = state_d == S_DONE;
    prod    = {{7{val_d[8]}}, val_d} << lut_shift;
    addr_d  = we_d ? lut_addr : 7'd0;
    data_d  = (state_d == S_VALUE) ? {{16{prod[15]}}, prod} : 32'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      run_q   <= '0;
      val_q   <= '0;
      qsel_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      run_q   <= run_d;
      val_q   <= val_d;
      qsel_q  <= qsel_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign sym_ready         = ready_q;
  assign DP_write_enable_a = we_q;
  assign DP_RAM_address_a  = addr_q;
  assign DP_write_DATA_a   = data_q;
  assign busy              = busy_q;
  assign finish            = fin_q;
  assign run_error         = err_q;

endmodule

// File: tb/tb_dequant_block.sv
// Directed bench for dequant_block.
// Hand-computed expectations, immediate-assert checks.
module tb_dequant_block;

  logic        Clock_50 = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        q_select = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [5:0]  sym_run = '0;
  logic [8:0]  sym_value = '0;
  logic        sym_eob = 1'b0;
  logic [6:0]  DP_RAM_address_a;
  logic [31:0] DP_write_DATA_a;
  logic        DP_write_enable_a;
  logic        busy;
  logic        finish;
  logic        run_error;

  dequant_block dut (
    .Clock_50          (Clock_50),
    .Reset             (Reset),
    .start             (start),
    .q_select          (q_select),
    .sym_valid         (sym_valid),
    .sym_ready         (sym_ready),
    .sym_run           (sym_run),
    .sym_value         (sym_value),
    .sym_eob           (sym_eob),
    .DP_RAM_address_a  (DP_RAM_address_a),
    .DP_write_DATA_a   (DP_write_DATA_a),
    .DP_write_enable_a (DP_write_enable_a),
    .busy              (busy),
    .finish            (finish),
    .run_error         (run_error)
  );

  always #5 Clock_50 = ~Clock_50;

  int checks = 0;
  int failures = 0;

  int zz [64] = '{
    0,  1,  8,  16, 9,  2,  3,  10,
    17, 24, 32, 25, 18, 11, 4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13, 6,  7,  14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [31:0] mem [64];
  logic [63:0] seen;
  int wcnt = 0, dups = 0, ord_err = 0;
  int fin_cnt = 0, cyc = 0, last_wr = 0, fin_cyc = 0;
  logic fin_busy = 1'b0;
  logic busy_prev = 1'b0;

  // Write monitor; per-block records restart when busy rises.
  always @(negedge Clock_50) begin
    cyc = cyc + 1;
    if (busy && !busy_prev) begin
      wcnt = 0; dups = 0; ord_err = 0; fin_cnt = 0; seen = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
    end
    busy_prev = busy;
    if (DP_write_enable_a) begin
      if (wcnt < 64 && DP_RAM_address_a != 7'(zz[wcnt]))
        ord_err = ord_err + 1;
      if (seen[DP_RAM_address_a[5:0]]) dups = dups + 1;
      seen[DP_RAM_address_a[5:0]] = 1'b1;
      mem[DP_RAM_address_a[5:0]] = DP_write_DATA_a;
      wcnt = wcnt + 1;
      last_wr = cyc;
    end
    if (finish) begin
      fin_cnt = fin_cnt + 1;
      fin_cyc = cyc;
      fin_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock_50);
    #1;
  endtask

  function automatic int nz_except(input int skip);
    int n = 0;
    for (int i = 0; i < 64; i++)
      if (i != skip && mem[i] != 32'd0) n++;
    return n;
  endfunction

  task automatic start_blk(input logic q);
    tick();
    start = 1'b1;
    q_select = q;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic eob, input logic [5:0] run,
                      input logic [8:0] val, input int gap);
    int t = 0;
    tick();
    repeat (gap) tick();
    sym_valid = 1'b1;
    sym_eob = eob;
    sym_run = run;
    sym_value = val;
    while (!sym_ready && t < 400) begin
      tick();
      t++;
    end
    chk("sym_accept", 32'(sym_ready), 32'd1);
    @(posedge Clock_50);
    #1;
    sym_valid = 1'b0;
    sym_eob = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    int t = 0;
    while (fin_cnt == 0 && t < 400) begin
      tick();
      t++;
    end
    chk({tag, "_finish"}, 32'(fin_cnt > 0), 32'd1);
    tick();
    tick();
    chk({tag, "_fin_once"}, 32'(fin_cnt), 32'd1);
    chk({tag, "_wcnt"}, 32'(wcnt), 32'd64);
    chk({tag, "_dups"}, 32'(dups), 32'd0);
    chk({tag, "_order"}, 32'(ord_err), 32'd0);
    chk({tag, "_fin_lat"}, 32'(fin_cyc - last_wr), 32'd1);
    chk({tag, "_fin_busy"}, 32'(fin_busy), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", 32'(sym_ready), 32'd0);
    chk("rst_we", 32'(DP_write_enable_a), 32'd0);
    chk("rst_addr", 32'(DP_RAM_address_a), 32'd0);
    chk("rst_data", DP_write_DATA_a, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_err", 32'(run_error), 32'd0);
    Reset = 1'b0;

    // q0: (run0,+5), EOB
    start_blk(1'b0);
    chk("a_busy", 32'(busy), 32'd1);
    send(1'b0, 6'd0, 9'd5, 0);
    send(1'b1, 6'd0, 9'd0, 0);
    wait_fin("a");
    chk("a_m0", mem[0], 32'd40);
    chk("a_rest", 32'(nz_except(0)), 32'd0);
    chk("a_err", 32'(run_error), 32'd0);
    chk("a_idle_we", 32'(DP_write_enable_a), 32'd0);

    // q1: (run1,-3), EOB
    start_blk(1'b1);
    send(1'b0, 6'd1, 9'h1FD, 0);
    send(1'b1, 6'd0, 9'd0, 0);
    wait_fin("b");
    chk("b_m0", mem[0], 32'd0);
    chk("b_m1", mem[1], 32'hFFFFFFFA);
    chk("b_rest", 32'(nz_except(1)), 32'd0);

    // q0: 64 x (run0,+1), no EOB
    start_blk(1'b0);
    for (int k = 0; k < 64; k++) send(1'b0, 6'd0, 9'd1, 0);
    wait_fin("c");
    chk("c_m0", mem[0], 32'd8);
    chk("c_m1", mem[1], 32'd4);
    chk("c_m7", mem[7], 32'd32);
    chk("c_m18", mem[18], 32'd16);
    chk("c_m56", mem[56], 32'd32);
    chk("c_m63", mem[63], 32'd64);

    // q0: (run63,-256) lands exactly on the last position
    start_blk(1'b0);
    send(1'b0, 6'd63, 9'h100, 0);
    wait_fin("d");
    chk("d_m63", mem[63], 32'hFFFFC000);
    chk("d_rest", 32'(nz_except(63)), 32'd0);
    chk("d_err", 32'(run_error), 32'd0);

    // q0: (run62,+1), (run5,+1) overflows
    start_blk(1'b0);
    send(1'b0, 6'd62, 9'd1, 0);
    send(1'b0, 6'd5, 9'd1, 0);
    wait_fin("e");
    chk("e_m62", mem[62], 32'd64);
    chk("e_m63", mem[63], 32'd0);
    chk("e_rest", 32'(nz_except(62)), 32'd0);
    chk("e_err", 32'(run_error), 32'd1);

    // q1: varying values, random gaps, start pulsed while busy
    start_blk(1'b1);
    chk("f_err_clr", 32'(run_error), 32'd0);
    for (int k = 0; k < 64; k++) begin
      if (k == 10) begin
        start_blk(1'b0);
        chk("f_busy", 32'(busy), 32'd1);
      end
      send(1'b0, 6'd0, 9'(k - 20), int'($urandom_range(0, 3)));
    end
    wait_fin("f");
    chk("f_m0", mem[0], 32'hFFFFFF60);
    chk("f_m1", mem[1], 32'hFFFFFFDA);
    chk("f_m8", mem[8], 32'hFFFFFFDC);
    chk("f_m11", mem[11], 32'hFFFFFFE4);
    chk("f_m27", mem[27], 32'h20);
    chk("f_m36", mem[36], 32'h130);
    chk("f_m40", mem[40], 32'd0);
    chk("f_m63", mem[63], 32'h560);

    // Reset after 20 writes, then a fresh block
    start_blk(1'b0);
    send(1'b0, 6'd62, 9'd1, 0);
    begin
      int t = 0;
      while (wcnt < 20 && t < 200) begin
        tick();
        t++;
      end
    end
    chk("g_reach20", 32'(wcnt), 32'd20);
    Reset = 1'b1;
    tick();
    chk("g_we", 32'(DP_write_enable_a), 32'd0);
    chk("g_busy", 32'(busy), 32'd0);
    chk("g_ready", 32'(sym_ready), 32'd0);
    repeat (3) tick();
    chk("g_wstop", 32'(wcnt), 32'd20);
    Reset = 1'b0;
    start_blk(1'b1);
    send(1'b0, 6'd3, 9'd7, 0);
    send(1'b1, 6'd0, 9'd0, 0);
    wait_fin("h");
    chk("h_m16", mem[16], 32'd14);
    chk("h_rest", 32'(nz_except(16)), 32'd0);
    chk("h_err", 32'(run_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
